// File: rtl/mem_crc_checker.sv
// Bit-serial CRC checker for codewords read from the CRC-protected memory.
// Rotates {data, crc} through an LFSR and reports payload, syndrome and error count.
module mem_crc_checker #(
   parameter int DATA_W = 8,
   parameter int CRC_W = 4,
   parameter logic [CRC_W-1:0] POLY = 4'h3,
   parameter int CNT_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W+CRC_W-1:0]   in_code,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_err,
   output logic [CRC_W-1:0]          out_syndrome,
   output logic [CNT_W-1:0]          err_count,
   input  logic                      err_clr
);

   localparam int CW = DATA_W + CRC_W;
   localparam int CB = $clog2(CW);
   localparam logic [CB-1:0] LAST = CB'(CW - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    sreg;
   logic [CRC_W-1:0] rem;
   logic [CB-1:0]    cnt;

   logic             fb;
   logic [CRC_W-1:0] rem_nxt;
   logic [CW-1:0]    sreg_nxt;
   logic             take;
   logic             give;

   always_comb begin
      fb       = rem[CRC_W-1] ^ sreg[CW-1];
      rem_nxt  = {rem[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      // Rotation restores the original word after CW steps, so the payload
      // can be taken from the shift register when the word completes.
      sreg_nxt = {sreg[CW-2:0], sreg[CW-1]};
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign take      = in_valid && in_ready;
   assign give      = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         sreg         <= '0;
         rem          <= '0;
         cnt          <= '0;
         out_data     <= '0;
         out_err      <= 1'b0;
         out_syndrome <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  sreg  <= in_code;
                  rem   <= '0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sreg <= sreg_nxt;
               rem  <= rem_nxt;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  out_data     <= sreg_nxt[CW-1:CRC_W];
                  out_syndrome <= rem_nxt;
                  out_err      <= |rem_nxt;
                  state        <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (give && out_err && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_crc_checker.sv
// Directed and randomized bench for mem_crc_checker against a
// polynomial-division reference model.
module tb_mem_crc_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_code;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_err;
   logic [3:0]  out_syndrome;
   logic [7:0]  err_count;
   logic        err_clr;

   int checks = 0;
   int errors = 0;
   int model_cnt = 0;

   mem_crc_checker dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_code(in_code),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_err(out_err),
      .out_syndrome(out_syndrome),
      .err_count(err_count),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Remainder of v(x) divided by x^4 + x + 1 by GF(2) long division.
   function automatic logic [3:0] pmod(input logic [15:0] v);
      logic [15:0] g;
      for (int i = 15; i >= 4; i--) begin
         g = 16'h0013 << (i - 4);
         if (v[i]) v = v ^ g;
      end
      return v[3:0];
   endfunction

   function automatic logic [3:0] ref_syn(input logic [11:0] cw);
      return pmod({cw, 4'h0});
   endfunction

   function automatic logic [11:0] make_cw(input logic [7:0] d);
      return {d, pmod({4'h0, d, 4'h0})};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_word(input logic [11:0] cw, input int stall,
                           input logic clr);
      int lat;
      logic [3:0] syn;
      logic [7:0] d0;
      logic [3:0] s0;
      logic e0;
      syn = ref_syn(cw);
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_code  = cw;
      @(negedge clk);
      in_valid = 1'b0;
      in_code  = 12'($urandom);
      chk("busy_ready", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'd12);
      chk("data", 32'(out_data), 32'(cw[11:4]));
      chk("syndrome", 32'(out_syndrome), 32'(syn));
      chk("err", 32'(out_err), 32'(syn != 4'h0));
      d0 = out_data;
      s0 = out_syndrome;
      e0 = out_err;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         in_code  = 12'($urandom);
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_ready", 32'(in_ready), 32'd0);
         chk("hold_out", {out_data, out_syndrome, 3'b0, out_err},
             {d0, s0, 3'b0, e0});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      err_clr   = clr;
      @(negedge clk);
      out_ready = 1'b0;
      err_clr   = 1'b0;
      if (clr) model_cnt = 0;
      else if (syn != 4'h0 && model_cnt < 255) model_cnt++;
      chk("release_valid", 32'(out_valid), 32'd0);
      chk("release_ready", 32'(in_ready), 32'd1);
      chk("err_count", 32'(err_count), 32'(model_cnt));
      chk("retain_data", 32'(out_data), 32'(cw[11:4]));
   endtask

   initial begin
      logic [11:0] cw;
      logic [11:0] words [3];
      int t_out [$];
      logic [7:0] d_out [$];
      logic e_out [$];
      int k;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_code   = 12'h0;
      out_ready = 1'b0;
      err_clr   = 1'b0;
      #1;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_outs", {out_data, out_syndrome, 3'b0, out_err}, 32'd0);
      chk("rst_cnt", 32'(err_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      chk("gen_a5", 32'(make_cw(8'hA5)), 32'hA5B);
      run_word(12'hA5B, 0, 1'b0);
      run_word(12'hA5A, 0, 1'b0);
      run_word(make_cw(8'h3C) ^ 12'h010, 5, 1'b0);

      for (int i = 0; i < 10; i++) begin
         cw = make_cw(8'($urandom));
         if (i % 2 == 1) cw = cw ^ (12'h1 << $urandom_range(11, 0));
         run_word(cw, $urandom_range(3, 0), 1'b0);
      end

      // Abort a word with reset in the middle of shifting.
      @(negedge clk);
      in_valid = 1'b1;
      in_code  = 12'hA5A;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      model_cnt = 0;
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_cnt", 32'(err_count), 32'd0);
      chk("mid_rst_syn", 32'(out_syndrome), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_word(12'h000, 0, 1'b0);

      // Back-to-back traffic with both handshakes held high.
      words[0] = 12'hA5B;
      words[1] = 12'hA5A;
      words[2] = 12'hA5B;
      k = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (out_valid) begin
            t_out.push_back(c);
            d_out.push_back(out_data);
            e_out.push_back(out_err);
         end
         if (in_ready) begin
            if (k < 3) begin
               in_valid = 1'b1;
               in_code  = words[k];
               k++;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      model_cnt++;
      chk("b2b_count", 32'(t_out.size()), 32'd3);
      if (t_out.size() == 3) begin
         chk("b2b_gap0", 32'(t_out[1] - t_out[0]), 32'd14);
         chk("b2b_gap1", 32'(t_out[2] - t_out[1]), 32'd14);
         for (int i = 0; i < 3; i++) begin
            chk("b2b_data", 32'(d_out[i]), 32'(words[i][11:4]));
            chk("b2b_err", 32'(e_out[i]), 32'(ref_syn(words[i]) != 4'h0));
         end
      end
      @(negedge clk);
      chk("b2b_errcnt", 32'(err_count), 32'(model_cnt));

      for (int i = 0; i < 256; i++) run_word(12'hA5A, 0, 1'b0);
      chk("sat_ff", 32'(err_count), 32'hFF);
      run_word(12'hA5A, 1, 1'b0);
      chk("sat_hold", 32'(err_count), 32'hFF);
      run_word(12'hA5A, 0, 1'b1);
      chk("clr_prio", 32'(err_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_crc_checker.md
Name: mem_crc_checker

Overview:
- Downstream consumer of the 16x12 CRC-protected memory's read_data port.
- Accepts one 12-bit codeword, laid out as {data[7:0], crc[3:0]}, through a valid/ready handshake.
- Recomputes the CRC bit-serially, one bit per cycle, with an LFSR.
- Returns the 8-bit payload, an error flag and the 4-bit syndrome, and keeps a saturating count of detected errors for status reporting.

Parameters:
- DATA_W, 8, payload width.
- CRC_W, 4, CRC width; codeword width CW = DATA_W + CRC_W = 12.
- POLY, 4'h3, generator polynomial without its top term (x^4 + x + 1).
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  single clock; rising-edge.
- rst  input  1  asynchronous, active-low reset (low = reset).
- in_valid  input  1  codeword present on in_code.
- in_ready  output  1  block can accept a codeword.
- in_code  input  CW  codeword, MSB first {data, crc}; from memory read_data.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  DATA_W  in_code[CW-1:CRC_W] of the accepted word.
- out_err  output  1  1 = nonzero syndrome.
- out_syndrome  output  CRC_W  final LFSR remainder.
- err_count  output  CNT_W  number of errored results handed off, saturating.
- err_clr  input  1  synchronous clear of err_count.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; in_ready = 1; out_valid = 0.
  - out_data, out_err, out_syndrome, err_count, internal shift register, remainder and bit counter all = 0.
  - Reset asserted mid-SHIFT or mid-DONE aborts the word; no result is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On the edge where in_valid && in_ready: latch in_code into the shift register, remainder = 0, counter = 0, go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - Each edge consumes the shift register MSB b:
    - fb = rem[CRC_W-1] ^ b
    - rem <= {rem[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 0)
    - shift register shifts left, counter increments.
  - On the edge consuming bit CW-1 (counter == CW-1): go to DONE.
- DONE:
  - out_valid = 1.
  - out_data, out_syndrome = rem, out_err = |rem are stable.
  - Hold while out_ready = 0; outputs must not change under backpressure.
  - On the edge with out_ready = 1: go to IDLE.
- Latency: out_valid rises on the 12th (CW-th) rising edge after the accepting edge.
- Throughput: minimum 14 cycles per word. in_ready is never high in SHIFT or DONE, so there is no accept/deliver overlap.
- A valid codeword yields syndrome 0. The algorithm is the standard non-augmented CRC (data*x^4 mod g), so the same LFSR generates the CRC on the write side.
- err_count:
  - On an output handshake edge with out_err = 1: increment.
  - Saturates at 2^CNT_W-1.
  - err_clr = 1 clears it to 0 on that edge and takes priority over a simultaneous increment.
- out_data, out_err and out_syndrome are registered; they retain the last result in IDLE and SHIFT. Only out_valid qualifies them.
- in_code changing after acceptance has no effect.

Test Plan:
- Reset, then in_code = 12'hA5B with in_valid pulsed for 1 cycle -> accepted; out_valid high 12 edges later with out_data = 8'hA5, out_syndrome = 4'h0, out_err = 0; err_count stays 0.
- in_code = 12'hA5A (LSB flipped) -> out_data = 8'hA5, out_syndrome = 4'h3, out_err = 1; err_count = 1 after the handshake.
- Hold out_ready = 0 for 5 cycles in DONE with in_valid = 1 and a new in_code -> out_* stable, in_ready = 0, new word not accepted. Release -> IDLE, then the next word is accepted on the following edge.
- Drive rst low at the 6th SHIFT edge -> asynchronously in_ready = 1, out_valid = 0, err_count = 0. After release, 12'h000 -> syndrome 0, out_err = 0.
- Feed 256 errored words (12'hA5A) -> err_count saturates at 8'hFF and stays there. Assert err_clr on the same edge as an errored handshake -> err_count = 0.
- Back-to-back traffic with in_valid and out_ready held high, words 12'hA5B, 12'hA5A, 12'hA5B -> results delivered in order, spaced exactly 14 cycles apart, with err flags 0, 1, 0.
